// File: rtl/kb_row_debouncer.sv
// rtl/kb_row_debouncer.sv - per-key row debouncer with key-state vector and press/release event FIFO
// A key flips only after DEBOUNCE_SCANS disagreeing samples of its column; at most one flip per sample.
module kb_row_debouncer #(
    parameter int COLS           = 8,
    parameter int ROWS           = 5,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int EVT_DEPTH      = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 sample_en,
    input  logic [3:0]           col_idx,
    input  logic [ROWS-1:0]      row_n,
    output logic [COLS*ROWS-1:0] keys_state,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [5:0]           event_code,
    output logic                 event_press,
    output logic                 overflow,
    input  logic                 overflow_clr
);
    localparam int NKEYS = COLS * ROWS;
    localparam int KW    = $clog2(NKEYS);
    localparam int CW    = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam int AW    = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int OW    = $clog2(EVT_DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);

    logic [NKEYS-1:0] keys_q, keys_d;
    logic [CW-1:0]    cnt_q [NKEYS];
    logic [CW-1:0]    cnt_d [NKEYS];
    logic [6:0]       mem_q [EVT_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [6:0]       last_q, last_d;
    logic             ovf_q, ovf_d;

    logic             fifo_full, push, pop, candidate_seen, raw;
    logic [6:0]       push_data;
    logic [KW-1:0]    k;

    assign fifo_full = (occ_q == OW'(EVT_DEPTH));
    assign pop       = event_valid & event_ready;

    // Only the lowest-row candidate of the sample may commit; the rest hold their counters.
    always_comb begin
        keys_d         = keys_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q & ~overflow_clr;
        push           = 1'b0;
        push_data      = '0;
        candidate_seen = 1'b0;
        raw            = 1'b0;
        k              = '0;
        if (sample_en && (int'(col_idx) < COLS)) begin
            for (int r = 0; r < ROWS; r++) begin
                k   = KW'(col_idx) * KW'(ROWS) + KW'(r);
                raw = ~row_n[r];
                if (raw == keys_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] != CNT_MAX) begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end else if (!candidate_seen) begin
                    candidate_seen = 1'b1;
                    if (!fifo_full) begin
                        keys_d[k] = raw;
                        cnt_d[k]  = '0;
                        push      = 1'b1;
                        push_data = {6'(k), raw};
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        occ_d  = occ_q + OW'(push) - OW'(pop);
        last_d = pop ? mem_q[rd_q] : last_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            keys_q <= '0;
            cnt_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            occ_q  <= '0;
            last_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            keys_q <= keys_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            occ_q  <= occ_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    // When empty the outputs hold the most recently popped entry.
    assign event_valid                = (occ_q != '0);
    assign {event_code, event_press}  = event_valid ? mem_q[rd_q] : last_q;
    assign keys_state                 = keys_q;
    assign overflow                   = ovf_q;
endmodule

// File: tb/tb_kb_row_debouncer.sv
// tb/tb_kb_row_debouncer.sv - directed and randomized bench with a queue-based reference model
module tb_kb_row_debouncer;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [3:0]  col_idx = 4'd0;
    logic [4:0]  row_n = 5'h1f;
    logic [39:0] keys_state;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [5:0]  event_code;
    logic        event_press;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    kb_row_debouncer dut (
        .Clk(Clk), .Rst(Rst), .sample_en(sample_en), .col_idx(col_idx), .row_n(row_n),
        .keys_state(keys_state), .event_valid(event_valid), .event_ready(event_ready),
        .event_code(event_code), .event_press(event_press), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each key debounced independently, events kept in a plain queue.
    bit         m_keys [40];
    int         m_cnt  [40];
    bit [6:0]   mq [$];
    bit [6:0]   m_last;
    bit         m_ovf;
    bit         started = 0;

    always @(posedge Clk) begin
        bit do_pop, full, push, taken, rawv;
        bit [6:0] pv;
        if (Rst) begin
            foreach (m_keys[i]) begin m_keys[i] = 0; m_cnt[i] = 0; end
            mq.delete();
            m_last = '0;
            m_ovf = 0;
            started = 1;
        end else begin
            do_pop = (mq.size() > 0) && event_ready;
            full = (mq.size() == 4);
            push = 0;
            taken = 0;
            pv = '0;
            if (overflow_clr) m_ovf = 0;
            if (sample_en && col_idx < 8) begin
                for (int r = 0; r < 5; r++) begin
                    int key;
                    key = col_idx * 5 + r;
                    rawv = !row_n[r];
                    if (rawv == m_keys[key]) m_cnt[key] = 0;
                    else if (m_cnt[key] < 2) m_cnt[key]++;
                    else if (!taken) begin
                        taken = 1;
                        if (!full) begin
                            m_keys[key] = rawv;
                            m_cnt[key] = 0;
                            push = 1;
                            pv = {6'(key), rawv};
                        end else m_ovf = 1;
                    end
                end
            end
            if (do_pop) begin m_last = mq[0]; void'(mq.pop_front()); end
            if (push) mq.push_back(pv);
        end
    end

    always @(negedge Clk) begin
        logic [39:0] ek;
        logic [6:0]  eh;
        if (started) begin
            foreach (m_keys[i]) ek[i] = m_keys[i];
            eh = (mq.size() > 0) ? mq[0] : m_last;
            chk("keys_state", keys_state, ek);
            chk("event_valid", event_valid, mq.size() > 0);
            chk("event_head", {event_code, event_press}, eh);
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic samp(input logic [3:0] c, input logic [4:0] r, input int n);
        repeat (n) begin
            sample_en = 1'b1; col_idx = c; row_n = r;
            @(negedge Clk);
        end
        sample_en = 1'b0; row_n = 5'h1f; col_idx = 4'd0;
    endtask

    task automatic pop(input int n);
        event_ready = 1'b1;
        repeat (n) @(negedge Clk);
        event_ready = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    bit [4:0]    tgt [8];
    logic [39:0] saved;
    bit          busy_mode;

    initial begin
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        chk("rst_keys", keys_state, 40'h0);
        chk("rst_valid", event_valid, 1'b0);
        chk("rst_code", event_code, 6'd0);
        chk("rst_press", event_press, 1'b0);
        chk("rst_ovf", overflow, 1'b0);

        samp(4'd2, 5'b11101, 2);
        chk("k11_after2", keys_state[11], 1'b0);
        samp(4'd2, 5'b11101, 1);
        chk("k11_press", keys_state[11], 1'b1);
        chk("k11_valid", event_valid, 1'b1);
        chk("k11_evt", {event_code, event_press}, {6'd11, 1'b1});
        pop(1);
        chk("k11_popped", event_valid, 1'b0);
        chk("k11_hold", {event_code, event_press}, {6'd11, 1'b1});
        samp(4'd2, 5'b11111, 3);
        chk("k11_rel", {event_code, event_press, keys_state[11]}, {6'd11, 1'b0, 1'b0});
        pop(1);

        samp(4'd2, 5'b11101, 2);
        samp(4'd2, 5'b11111, 1);
        samp(4'd2, 5'b11101, 2);
        chk("bounce_keys", keys_state[11], 1'b0);
        chk("bounce_valid", event_valid, 1'b0);
        samp(4'd2, 5'b11111, 1);

        samp(4'd0, 5'b10110, 3);
        chk("dual_first", {event_code, event_press}, {6'd0, 1'b1});
        chk("dual_k3_wait", keys_state[3], 1'b0);
        samp(4'd0, 5'b10110, 1);
        chk("dual_k3", keys_state[3], 1'b1);
        pop(1);
        chk("dual_second", {event_code, event_press}, {6'd3, 1'b1});
        pop(1);
        samp(4'd0, 5'b11111, 4);
        pop(2);
        chk("dual_drained", event_valid, 1'b0);

        for (int c = 3; c < 8; c++) samp(4'(c), 5'b11110, 3);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_keys", $countones(keys_state), 4);
        chk("ovf_k35", keys_state[35], 1'b0);
        chk("ovf_head", event_code, 6'd15);
        pop(4);
        chk("ovf_empty", event_valid, 1'b0);
        samp(4'd7, 5'b11110, 1);
        chk("ovf_retry", {event_code, event_press, keys_state[35]}, {6'd35, 1'b1, 1'b1});
        chk("ovf_sticky", overflow, 1'b1);
        overflow_clr = 1'b1;
        @(negedge Clk);
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
        pop(1);

        saved = keys_state;
        samp(4'd9, 5'b00000, 3);
        chk("col9_ignored", keys_state, saved);

        do_reset();
        samp(4'd1, 5'b11011, 2);
        do_reset();
        samp(4'd1, 5'b11011, 2);
        chk("rst_mid_cnt", keys_state[7], 1'b0);
        samp(4'd1, 5'b11011, 1);
        chk("rst_fresh3", keys_state[7], 1'b1);
        samp(4'd1, 5'b11111, 2);
        Rst = 1'b1; sample_en = 1'b1; col_idx = 4'd1; row_n = 5'h1f;
        @(negedge Clk);
        Rst = 1'b0; sample_en = 1'b0;
        chk("rst_wins_keys", keys_state, 40'h0);
        chk("rst_wins_valid", event_valid, 1'b0);

        samp(4'd0, 5'b11110, 3);
        samp(4'd1, 5'b11110, 3);
        samp(4'd2, 5'b11110, 3);
        samp(4'd3, 5'b11110, 2);
        event_ready = 1'b1;
        samp(4'd3, 5'b11110, 1);
        event_ready = 1'b0;
        chk("pp_head", event_code, 6'd5);
        pop(1);
        chk("pp_order1", event_code, 6'd10);
        pop(1);
        chk("pp_order2", event_code, 6'd15);
        pop(1);
        chk("pp_empty", event_valid, 1'b0);

        foreach (tgt[i]) tgt[i] = 5'h1f;
        busy_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            int c;
            if (i % 250 == 0) busy_mode = ~busy_mode;
            Rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 29) == 0) tgt[$urandom_range(0, 7)] = 5'($urandom);
            c = $urandom_range(0, 9);
            sample_en = ($urandom_range(0, 2) != 0);
            col_idx = 4'(c);
            row_n = (c < 8) ? tgt[c] : 5'($urandom);
            if ($urandom_range(0, 7) == 0) row_n[$urandom_range(0, 4)] ^= 1'b1;
            event_ready = busy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            overflow_clr = ($urandom_range(0, 24) == 0);
            @(negedge Clk);
        end
        Rst = 1'b0; sample_en = 1'b0; event_ready = 1'b0; overflow_clr = 1'b0;
        @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
